// File: rtl/branch_target_buffer_assoc.sv
// branch_target_buffer_assoc: set-associative BTB with 2-bit counters, tree-PLRU replacement and a one-cycle flush.
// The lookup is registered; updates come from the resolve stage and are read-before-write against a same-cycle lookup.
module branch_target_buffer_assoc #(
    parameter int         SETS     = 1024,
    parameter int         WAYS     = 2,
    parameter int         PC_W     = 32,
    parameter logic [1:0] CTR_INIT = 2'b10
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [PC_W:1]                             PC_in,
    output logic [1:0]                                status,
    output logic [PC_W:1]                             PC_predict_o,
    output logic                                      hit,
    output logic [(WAYS > 1 ? $clog2(WAYS) : 1)-1:0]  hit_way,
    input  logic                                      en_1,
    input  logic [PC_W:1]                             PC_update,
    input  logic                                      taken_update,
    input  logic [PC_W:1]                             PC_predict_update,
    input  logic                                      flush
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam int WW    = WAYS > 1 ? $clog2(WAYS) : 1;

    logic [WAYS-1:0]  valid_q [SETS];
    logic [2:0]       plru_q  [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [1:0]       ctr_q   [SETS][WAYS];
    logic [PC_W:1]    tgt_q   [SETS][WAYS];

    logic          hit_q, hit_d;
    logic [1:0]    status_q, status_d;
    logic [PC_W:1] pred_q, pred_d;
    logic [WW-1:0] way_q, way_d;

    logic [IDX_W-1:0] l_idx, u_idx;
    logic [TAG_W-1:0] l_tag, u_tag;
    logic             u_hit, inv_any, upd;
    int               hit_w, inv_w, vic, sel;
    logic [1:0]       old_ctr, ctr_new;
    logic [2:0]       pl, plru_set_d;
    logic [WAYS-1:0]  valid_set_d;

    assign l_idx = PC_in[IDX_W+2:3];
    assign l_tag = PC_in[PC_W:IDX_W+3];
    assign u_idx = PC_update[IDX_W+2:3];
    assign u_tag = PC_update[PC_W:IDX_W+3];

    always_comb begin
        hit_d    = 1'b0;
        status_d = '0;
        pred_d   = '0;
        way_d    = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (valid_q[l_idx][i] && tag_q[l_idx][i] == l_tag) begin
                hit_d    = 1'b1;
                status_d = ctr_q[l_idx][i];
                pred_d   = tgt_q[l_idx][i];
                way_d    = WW'(i);
            end
        end
    end

    // Descending scan so the lowest-numbered invalid way wins.
    always_comb begin
        u_hit   = 1'b0;
        hit_w   = 0;
        inv_any = 1'b0;
        inv_w   = 0;
        old_ctr = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid_q[u_idx][i] && tag_q[u_idx][i] == u_tag) begin
                u_hit   = 1'b1;
                hit_w   = i;
                old_ctr = ctr_q[u_idx][i];
            end
            if (!valid_q[u_idx][i]) begin
                inv_any = 1'b1;
                inv_w   = i;
            end
        end
        pl  = plru_q[u_idx];
        vic = (WAYS == 4) ? (pl[0] ? (pl[2] ? 3 : 2) : (pl[1] ? 1 : 0)) :
              (WAYS == 2) ? int'(pl[0]) : 0;
        sel = u_hit ? hit_w : inv_any ? inv_w : vic;
        upd = en_1 && !flush && (u_hit || taken_update);
        ctr_new = !u_hit ? CTR_INIT :
                  taken_update ? (old_ctr == 2'd3 ? old_ctr : old_ctr + 2'd1) :
                                 (old_ctr == 2'd0 ? old_ctr : old_ctr - 2'd1);
        plru_set_d = pl;
        if (WAYS == 2) plru_set_d[0] = (sel == 0);
        if (WAYS == 4) begin
            plru_set_d[0] = (sel < 2);
            if (sel < 2) plru_set_d[1] = (sel == 0);
            else         plru_set_d[2] = (sel == 2);
        end
        for (int i = 0; i < WAYS; i++) valid_set_d[i] = valid_q[u_idx][i] | (i == sel);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
            hit_q    <= 1'b0;
            status_q <= '0;
            pred_q   <= '0;
            way_q    <= '0;
        end else begin
            hit_q    <= hit_d;
            status_q <= status_d;
            pred_q   <= pred_d;
            way_q    <= way_d;
            if (flush) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[s] <= '0;
                    plru_q[s]  <= '0;
                end
            end else if (upd) begin
                valid_q[u_idx] <= valid_set_d;
                plru_q[u_idx]  <= plru_set_d;
            end
        end
    end

    // Payload needs no reset: an entry is only observed through its valid bit.
    always_ff @(posedge clk) begin
        if (upd) begin
            for (int i = 0; i < WAYS; i++) begin
                if (i == sel) begin
                    tag_q[u_idx][i] <= u_tag;
                    ctr_q[u_idx][i] <= ctr_new;
                    if (taken_update) tgt_q[u_idx][i] <= PC_predict_update;
                end
            end
        end
    end

    assign hit          = hit_q;
    assign status       = status_q;
    assign PC_predict_o = pred_q;
    assign hit_way      = way_q;
endmodule

// File: tb/tb_branch_target_buffer_assoc.sv
// tb_branch_target_buffer_assoc: directed vector table plus hand sequences for flush and mid-stream reset.
module tb_branch_target_buffer_assoc;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in, pc_up, tgt_up, pred;
    logic [1:0]  status;
    logic        hit, hit_way, en_1, taken, flush;
    int          checks = 0, failures = 0;

    typedef struct {
        logic        en;
        logic [31:0] pcu;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] pci;
        logic        eh;
        logic [1:0]  es;
        logic [31:0] ep;
        logic        ew;
    } vec_t;
    vec_t v[23];

    branch_target_buffer_assoc dut (
        .clk(clk), .rst(rst), .PC_in(pc_in), .status(status), .PC_predict_o(pred),
        .hit(hit), .hit_way(hit_way), .en_1(en_1), .PC_update(pc_up),
        .taken_update(taken), .PC_predict_update(tgt_up), .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic eh, input logic [1:0] es, input logic [31:0] ep, input logic ew);
        checks++;
        if (hit !== eh || status !== es || pred !== ep || hit_way !== ew) begin
            failures++;
            $display("FAIL %s: got hit=%b status=%0d pred=%h way=%b, want hit=%b status=%0d pred=%h way=%b",
                     nm, hit, status, pred, hit_way, eh, es, ep, ew);
        end
    endtask

    initial begin
        // A=0x1000, B=0x2000, C=0x3000, D=0x6000 share set 0 with distinct tags.
        v[0]  = '{1, 32'h1000, 1, 32'h2000, 32'h1000, 0, 0, 32'h0,    0};
        v[1]  = '{0, 32'h0,    0, 32'h0,    32'h1000, 1, 2, 32'h2000, 0};
        v[2]  = '{1, 32'h1000, 1, 32'h2000, 32'h1000, 1, 2, 32'h2000, 0};
        v[3]  = '{1, 32'h1000, 1, 32'h2000, 32'h1000, 1, 3, 32'h2000, 0};
        v[4]  = '{1, 32'h1000, 1, 32'h2000, 32'h1000, 1, 3, 32'h2000, 0};
        v[5]  = '{0, 32'h0,    0, 32'h0,    32'h1000, 1, 3, 32'h2000, 0};
        v[6]  = '{1, 32'h1000, 0, 32'hBEEF, 32'h1000, 1, 3, 32'h2000, 0};
        v[7]  = '{1, 32'h1000, 0, 32'hBEEF, 32'h1000, 1, 2, 32'h2000, 0};
        v[8]  = '{1, 32'h1000, 0, 32'hBEEF, 32'h1000, 1, 1, 32'h2000, 0};
        v[9]  = '{1, 32'h1000, 0, 32'hBEEF, 32'h1000, 1, 0, 32'h2000, 0};
        v[10] = '{0, 32'h0,    0, 32'h0,    32'h1000, 1, 0, 32'h2000, 0};
        v[11] = '{1, 32'h2000, 1, 32'h2222, 32'h2000, 0, 0, 32'h0,    0};
        v[12] = '{1, 32'h3000, 1, 32'h3333, 32'h2000, 1, 2, 32'h2222, 1};
        v[13] = '{0, 32'h0,    0, 32'h0,    32'h1000, 0, 0, 32'h0,    0};
        v[14] = '{0, 32'h0,    0, 32'h0,    32'h3000, 1, 2, 32'h3333, 0};
        v[15] = '{1, 32'h2000, 1, 32'h4444, 32'h2000, 1, 2, 32'h2222, 1};
        v[16] = '{1, 32'h1000, 1, 32'h5555, 32'h2000, 1, 3, 32'h4444, 1};
        v[17] = '{0, 32'h0,    0, 32'h0,    32'h3000, 0, 0, 32'h0,    0};
        v[18] = '{0, 32'h0,    0, 32'h0,    32'h1000, 1, 2, 32'h5555, 0};
        v[19] = '{1, 32'h6000, 0, 32'h6666, 32'h6000, 0, 0, 32'h0,    0};
        v[20] = '{0, 32'h0,    0, 32'h0,    32'h6000, 0, 0, 32'h0,    0};
        v[21] = '{0, 32'h0,    0, 32'h0,    32'h2000, 1, 3, 32'h4444, 1};
        v[22] = '{0, 32'h0,    0, 32'h0,    32'h1003, 1, 2, 32'h5555, 0};

        rst = 1'b0; pc_in = 32'h1000; pc_up = '0; tgt_up = '0; en_1 = 0; taken = 0; flush = 0;
        step(); chk("reset0", 0, 0, 0, 0);
        step(); chk("reset1", 0, 0, 0, 0);
        rst = 1'b1;
        step(); chk("post_reset", 0, 0, 0, 0);

        for (int i = 0; i < 23; i++) begin
            en_1 = v[i].en; pc_up = v[i].pcu; taken = v[i].tk; tgt_up = v[i].tgt; pc_in = v[i].pci;
            step();
            chk($sformatf("vec%0d", i), v[i].eh, v[i].es, v[i].ep, v[i].ew);
        end

        for (int p = 1; p <= 4; p++) begin
            en_1 = 1; taken = 1; pc_up = 32'(p * 16); tgt_up = 32'(p * 16 + 256);
            step();
        end
        en_1 = 0; pc_in = 32'h30;
        step(); chk("fill_hit", 1, 2, 32'h130, 0);
        flush = 1; en_1 = 1; taken = 1; pc_up = 32'h50; tgt_up = 32'h150; pc_in = 32'h10;
        step(); chk("flush_prelookup", 1, 2, 32'h110, 0);
        flush = 0; en_1 = 0;
        for (int p = 1; p <= 6; p++) begin
            pc_in = (p == 6) ? 32'h1000 : 32'(p * 16);
            step(); chk($sformatf("flush_miss%0d", p), 0, 0, 0, 0);
        end

        en_1 = 1; taken = 1; pc_up = 32'h1000; tgt_up = 32'h7000; pc_in = 32'h1000;
        step(); chk("realloc_rbw", 0, 0, 0, 0);
        en_1 = 1; pc_up = 32'h2000; tgt_up = 32'h8000;
        step(); chk("realloc_hit", 1, 2, 32'h7000, 0);
        #2 rst = 1'b0;
        #1 chk("rst_async", 0, 0, 0, 0);
        step(); chk("rst_hold", 0, 0, 0, 0);
        rst = 1'b1; en_1 = 0;
        step(); chk("rst_miss_a", 0, 0, 0, 0);
        pc_in = 32'h2000;
        step(); chk("rst_miss_b", 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_target_buffer_assoc.md
# branch_target_buffer_assoc

Parametrised set-associative branch target buffer that replaces the direct-mapped status table in the fetch-stage predictor path. Each entry holds a valid bit, a PC tag, a 2-bit saturating direction counter and a predicted target. The block performs a registered lookup every cycle and a tag-matched or allocating update from the resolve stage. It adds associativity, true tag compare, in-block counter training, pseudo-LRU replacement and a single-cycle flush, none of which the previous table had.

## Interface
- SETS, 1024, number of sets; power of two, 2..16384; IDX_W = log2(SETS)
- WAYS, 2, associativity; legal values 1, 2, 4
- PC_W, 32, PC and target width; bits numbered [PC_W:1]
- CTR_INIT, 2'b10, counter value written on allocation (weakly taken)

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- PC_in  in  PC_W  lookup PC, sampled every cycle
- status  out  2  counter of the hitting way; 0 on miss
- PC_predict_o  out  PC_W  target of the hitting way; 0 on miss
- hit  out  1  registered lookup hit
- hit_way  out  max(1,log2 WAYS)  way that hit; 0 on miss
- en_1  in  1  update strobe from the resolve stage
- PC_update  in  PC_W  PC of the resolved branch
- taken_update  in  1  resolved direction
- PC_predict_update  in  PC_W  resolved target
- flush  in  1  synchronous invalidate-all request

## Operation
- Index = PC[IDX_W+2:3]; tag = PC[PC_W:IDX_W+3]; PC[2:1] are ignored.
- Storage per set and way: valid, tag, ctr[2:1], target. Per set: PLRU state with WAYS-1 bits; none when WAYS=1.
- Lookup: select the set by the PC_in index. A way hits when valid=1 and its tag equals the PC_in tag. At most one way hits, which the update rules guarantee.
  - On a hit, register status=ctr, PC_predict_o=target, hit=1, hit_way=way.
  - On a miss, register all four outputs as 0.
  - A valid entry with ctr=0 still reports hit=1 and status=0.
- Update when en_1=1, on the set given by the PC_update index:
  - Tag hit in way w: ctr saturates, incrementing on taken and decrementing on not-taken. The saturation bounds are 3 and 0; there is no wrap. target is written with PC_predict_update only when taken_update=1. PLRU is touched to make w the most recently used way.
  - Miss with taken_update=1: allocate one way. The choice is the lowest-numbered invalid way if any exist, otherwise the PLRU victim. The block writes valid=1, the tag, ctr=CTR_INIT and target=PC_predict_update, then touches PLRU for that way.
  - Miss with taken_update=0: no state change.
- PLRU: tree PLRU. For WAYS=2 the single bit points at the victim. For WAYS=4, node bit b0 selects the half {0,1} or {2,3}, and b1/b2 select within each half. A bit value of 0 means the victim is on the left. Only the update port modifies PLRU; lookups never do.
- Flush: clears every valid bit and every PLRU bit in one cycle. Tag, ctr and target contents need not be cleared.
- Simultaneous events:
  - If flush=1 and en_1=1 in the same cycle, flush wins and the update is dropped.
  - If a lookup and an update hit the same set in one cycle, the lookup returns the pre-update contents (read-before-write).
  - If a lookup coincides with a flush, the lookup returns the pre-flush contents.
- Reset, asserted at any time including mid-update:
  - All valid bits go to 0, all PLRU bits go to 0, and status, PC_predict_o, hit and hit_way go to 0.
  - Outputs stay 0 while rst=0, and updates are ignored.

## Timing
- Lookup latency: 1 cycle. The PC_in value presented before edge n drives the outputs from edge n until edge n+1.
- Update latency: 1 cycle. An update written at edge n is visible to a lookup sampled at edge n+1, with results appearing after edge n+1.
- Flush: takes effect at the edge where it is sampled high. A lookup sampled on the next edge misses.
- No stall or handshake exists. The block accepts one lookup and one update every cycle.
- Reset release: the first lookup is sampled at the first rising edge after rst goes high.

## Test plan
- Reset then lookup PC 0x0000_1000 -> hit=0, status=0, PC_predict_o=0 for every cycle.
- Update PC 0x1000 taken with target 0x2000, then look it up -> hit=1, status=2'b10, PC_predict_o=0x2000. Follow with 3 taken updates -> status=3, holding at 3. Follow with 4 not-taken updates -> status=0 with hit=1 and target still 0x2000.
- WAYS=2, SETS=1024: allocate PCs A=0x1000, B=0x2000, C=0x3000, all in the same set, taken -> C evicts A, so a lookup of A misses while B and C hit. Update B once more, then allocate A again -> A evicts C.
- Lookup and update of the same PC in the same cycle -> the first result is the miss/old value and the next cycle shows the new entry. A not-taken update on a missing PC causes no allocation, so a later lookup misses.
- Fill 4 sets, assert flush together with en_1 for a new PC -> all subsequent lookups miss, including the new PC.
- Assert rst low mid-stream while en_1=1 -> outputs go to 0 asynchronously and all lookups after release miss.
